multdiv_issue_ctrl: RTL

Processor-side initiator for the multdiv unit. Sits in the execute stage. It accepts a decoded mul/div request and registers the operands. It then pulses ctrl_Mult or ctrl_Div for one cycle, holds the operands stable, and waits for ready. Finally it returns either the result or an rstatus writeback, and stalls the pipeline for the whole operation.

---
 rtl/multdiv_issue_ctrl_pkg.sv | 27 ++
 rtl/multdiv_watchdog.sv | 29 ++
 rtl/multdiv_issue_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the multdiv issue controller and the ALU-overflow rstatus logic.
package multdiv_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } mdState_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } mdOp_t;

    localparam int          MD_TIMEOUT_CYCLES = 64;
    localparam logic [31:0] MD_STATUS_MUL     = 32'd4;
    localparam logic [31:0] MD_STATUS_DIV     = 32'd5;
    localparam logic [4:0]  MD_RSTATUS_REG    = 5'd30;

    function automatic logic [31:0] statusCode(input mdOp_t op,
                                               input logic [31:0] mulCode,
                                               input logic [31:0] divCode);
        return (op == OP_DIV) ? divCode : mulCode;
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// Saturating BUSY-cycle counter; o_expired flags the final allowed cycle without a response.
module multdiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TC)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = i_enable && (r_count == TC);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage initiator for the multdiv unit: latches a request, pulses start,
// waits for ready and returns the result or an rstatus writeback while stalling F/D/X.
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES,
    parameter logic [31:0] STATUS_MUL     = MD_STATUS_MUL,
    parameter logic [31:0] STATUS_DIV     = MD_STATUS_DIV,
    parameter logic [4:0]  RSTATUS_REG    = MD_RSTATUS_REG
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_Mult,
    output logic        md_ctrl_Div,
    input  logic [31:0] md_result,
    input  logic        md_except,
    input  logic        md_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    mdState_t    r_state;
    mdState_t    w_nextState;
    mdOp_t       r_op;
    logic [31:0] r_opA;
    logic [31:0] r_opB;
    logic [31:0] r_result;
    logic [4:0]  r_rd;
    logic        r_except;
    logic        r_aborted;
    logic        r_timeout;
    logic        w_accept;
    logic        w_active;
    logic        w_wdClear;
    logic        w_wdEnable;
    logic        w_expired;
    logic        w_wbAllowed;

    assign w_accept   = (r_state == ST_IDLE) && (issue_mult || issue_div) && !flush;
    assign w_active   = (r_state == ST_START) || (r_state == ST_BUSY);
    assign w_wdClear  = (r_state != ST_BUSY);
    assign w_wdEnable = (r_state == ST_BUSY) && !md_ready;

    multdiv_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_wdClear),
        .i_enable (w_wdEnable),
        .o_expired(w_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // md_ready takes priority over the watchdog when both land in the same BUSY cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_nextState = ST_START;
            ST_START: w_nextState = ST_BUSY;
            ST_BUSY: begin
                if (md_ready) begin
                    w_nextState = ST_DONE;
                end else if (w_expired) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // A flushed op cannot be cancelled in multdiv, so we still wait for ready and drop the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_opA     <= '0;
            r_opB     <= '0;
            r_rd      <= '0;
            r_op      <= OP_MUL;
            r_result  <= '0;
            r_except  <= 1'b0;
            r_aborted <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opA     <= issue_a;
                r_opB     <= issue_b;
                r_rd      <= issue_rd;
                r_op      <= issue_mult ? OP_MUL : OP_DIV;
                r_aborted <= 1'b0;
            end else if (w_active && flush) begin
                r_aborted <= 1'b1;
            end
            if ((r_state == ST_BUSY) && md_ready) begin
                r_result <= md_result;
                r_except <= md_except;
            end
            if (w_expired) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign md_operandA = r_opA;
    assign md_operandB = r_opB;
    assign timeout     = r_timeout;
    assign w_wbAllowed = !r_aborted && !flush;

    always_comb begin
        md_ctrl_Mult = (r_state == ST_START) && (r_op == OP_MUL);
        md_ctrl_Div  = (r_state == ST_START) && (r_op == OP_DIV);
        stall        = w_accept || (w_active && !r_aborted);
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        if (r_state == ST_DONE) begin
            if (r_except) begin
                wb_valid = w_wbAllowed;
                wb_rd    = RSTATUS_REG;
                wb_data  = statusCode(r_op, STATUS_MUL, STATUS_DIV);
            end else begin
                wb_valid = w_wbAllowed && (r_rd != 5'd0);
                wb_rd    = r_rd;
                wb_data  = r_result;
            end
        end
    end

endmodule
